adder_operand_loader: RTL
=========================

// Module: adder_operand_loader
// PURPOSE
//  Upstream operand stage for the pin-level adder: collects two WIDTH-bit operands one after the other
//  from the shared input pins, each captured on a rising edge of an external load strobe.
//  Presents the completed pair (op_a, op_b) to the adder over a valid/ready handshake and flags lost loads.
//  Sits between the ui_in pins and the adder core inside the top-level wrapper.
// PARAMETERS
//  WIDTH        4   operand width in bits
//  SYNC_STAGES  2   synchroniser depth on din and load (minimum 2)
//  DEB_CYCLES   4   consecutive stable cycles required by the debounce filter (used only with the macro)
// PORTS
//  clk        in   1      single clock; every flop is on its rising edge
//  reset      in   1      asynchronous, active-high reset
//  din        in   WIDTH  raw operand bits from the pins (asynchronous)
//  load       in   1      raw load strobe from a pin (asynchronous, level)
//  clear      in   1      synchronous abort: discard the partial or complete pair
//  op_ready   in   1      adder accepts the pair
//  op_valid   out  1      pair op_a/op_b is complete and held
//  op_a       out  WIDTH  first captured operand
//  op_b       out  WIDTH  second captured operand
//  overrun    out  1      sticky: a load edge arrived in FULL and was dropped
//  state_dbg  out  2      current FSM state encoding
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, op_valid=0, op_a=0, op_b=0, overrun=0, sync flops=0.
//  din and load pass through equal SYNC_STAGES chains so the data stays aligned with its strobe.
//  load_rise = synced load high and its previous sample low; one-cycle pulse.
//  Latency: the load pin rises -> load_rise asserts SYNC_STAGES+1 cycles later.
//  The synced din of that same cycle is captured.
//  FSM (encoding IDLE=0, HAVE_A=1, FULL=2; value 3 is illegal and returns to IDLE):
//   IDLE   : load_rise -> op_a<=din_s, go HAVE_A.
//   HAVE_A : load_rise -> op_b<=din_s, go FULL; op_valid asserts the next cycle.
//   FULL   : op_valid=1; op_a/op_b held stable until handshake.
//            op_valid && op_ready -> go IDLE, op_valid=0 next cycle.
//            load_rise without handshake -> dropped, overrun<=1.
//  A load_rise in the same cycle as the FULL handshake is dropped and sets overrun; no re-capture.
//  clear: any state -> IDLE next cycle and op_valid<=0; op_a/op_b keep their values.
//   clear also resets overrun to 0. clear beats load_rise and the handshake in the same cycle.
//  op_ready is ignored outside FULL. op_a/op_b change only on capture.
//  reset mid-operation discards everything; the first load_rise after reset captures op_a.
// CONFIGURATION
//  ADDER_LOADER_DEBOUNCE_EN defined:
//   The synced load must hold a new level for DEB_CYCLES consecutive cycles before the filtered level updates.
//   load_rise is taken from the filtered level, so latency becomes SYNC_STAGES+DEB_CYCLES+1.
//   Glitches shorter than DEB_CYCLES produce no capture.
//  Not defined: no filter; load_rise comes straight from the synced level.
// STRUCTURE
//  Package adder_pkg holds:
//   typedef enum logic [1:0] loader_state_t {IDLE, HAVE_A, FULL}
//   localparam ADDER_WIDTH = 4
//  Sub-module sync_edge_detect: SYNC_STAGES synchroniser, optional debounce, rising-edge pulse.
//  The FSM and operand registers sit in this module.
// TESTING
//  Load din=3, then din=5, hold op_ready=0 -> op_valid=1, op_a=3, op_b=5, state_dbg=2, both stable for 10 cycles.
//  Raise op_ready in FULL -> op_valid=0 and state_dbg=0 one cycle later; next load captures op_a.
//  Load 1, 2, then 7 while in FULL -> overrun=1, op_b stays 2; clear -> overrun=0, state_dbg=0.
//  Capture op_a=9, then clear and a load edge in the same cycle -> state IDLE, no op_b captured.
//  Assert reset in HAVE_A -> all outputs 0 immediately, without waiting for a clock edge.
//  Check the load-pin-to-capture latency is exactly SYNC_STAGES+1 cycles.
//  With ADDER_LOADER_DEBOUNCE_EN: a 2-cycle load pulse (DEB_CYCLES=4) -> no capture; a 6-cycle pulse -> one capture.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the pin-level adder and its operand loader.
package adder_pkg;
  localparam int ADDER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } loader_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises raw din/load pins through equal-depth chains and emits a registered one-cycle
// rising-edge pulse on load, aligned with the synced din. Optional filter: ADDER_LOADER_DEBOUNCE_EN.
module sync_edge_detect #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] din_s_o,
  output logic             rise_o
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0]            load_sync_q;
  logic [WIDTH-1:0]                  din_q;
  logic                              lvl, prev_q, rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_sync_q  <= '0;
      load_sync_q <= '0;
    end else begin
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din_i};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load_i};
    end
  end

`ifdef ADDER_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  logic             flt_q;
  logic [CNT_W-1:0] cnt_q;

  // The filtered level follows the synced level only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_sync_q[SYNC_STAGES-1] == flt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      flt_q <= load_sync_q[SYNC_STAGES-1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign lvl = flt_q;
`else
  assign lvl = load_sync_q[SYNC_STAGES-1];
`endif

  // Pulse and data are registered together so the FSM sees them on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      din_q  <= '0;
    end else begin
      prev_q <= lvl;
      rise_q <= lvl & ~prev_q;
      din_q  <= din_sync_q[SYNC_STAGES-1];
    end
  end

  assign din_s_o = din_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/adder_operand_loader.sv
// Collects two operands from shared pins on load-strobe edges and hands the pair to the adder
// over valid/ready; flags dropped loads. Optional load debounce: ADDER_LOADER_DEBOUNCE_EN.
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int WIDTH       = ADDER_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clear,
  input  logic             op_ready,
  output logic             op_valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             overrun,
  output logic [1:0]       state_dbg
);
  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_int = rst_q[1];

  logic [WIDTH-1:0] din_s;
  logic             load_rise;

  sync_edge_detect #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst_int),
    .din_i  (din),
    .load_i (load),
    .din_s_o(din_s),
    .rise_o (load_rise)
  );

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    ovr_d   = ovr_q;
    if (clear) begin
      state_d = IDLE;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (load_rise) begin
          op_a_d  = din_s;
          state_d = HAVE_A;
        end
        HAVE_A: if (load_rise) begin
          op_b_d  = din_s;
          state_d = FULL;
        end
        FULL: begin
          // A load edge here is lost even when the handshake completes on the same cycle.
          if (load_rise) ovr_d = 1'b1;
          if (op_ready)  state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign op_valid  = (state_q == FULL);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign overrun   = ovr_q;
  assign state_dbg = state_q;
endmodule
